// File: rtl/dm_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// State encoding, wait-counter width and byte-lane geometry.
package dm_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int WAIT_W = 4;
   localparam int BYTE_W = 8;
   localparam int LANES  = 4;

endpackage

// File: rtl/dm_responder_bank.sv
// dm_bank: DEPTH x 32 synchronous storage with per-byte write enables.
// Ports: clk, i_en (access strobe), i_we, i_be, i_idx, i_wdata, o_rdata.
module dm_bank
   import dm_responder_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             i_en,
   input  logic             i_we,
   input  logic [LANES-1:0] i_be,
   input  logic [AW-1:0]    i_idx,
   input  logic [31:0]      i_wdata,
   output logic [31:0]      o_rdata
);

   logic [31:0] r_mem [DEPTH];

   // Contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (i_en) begin
         if (i_we) begin
            for (int b = 0; b < LANES; b++) begin
               if (i_be[b]) begin
                  r_mem[i_idx][b*BYTE_W +: BYTE_W] <=
                     i_wdata[b*BYTE_W +: BYTE_W];
               end
            end
         end
         o_rdata <= r_mem[i_idx];
      end
   end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states.
// Ports: clk, reset (async low), req/we/addr/be/wdata in; busy, resp_valid, rdata, err out.
module dm_responder
   import dm_responder_pkg::*;
#(
   parameter int          DEPTH       = 1024,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [3:0]  be,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        resp_valid,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [32:0] LIMIT =
      {1'b0, ADDR_BASE} + 33'(DEPTH) * 33'd4;

   state_t            r_state;
   state_t            w_next;
   logic [WAIT_W-1:0] r_cnt;
   logic              r_we;
   logic [31:0]       r_addr;
   logic [3:0]        r_be;
   logic [31:0]       r_wdata;
   logic              r_err;

   logic              w_accept;
   logic              w_enter;
   logic              w_we;
   logic [31:0]       w_addr;
   logic [3:0]        w_be;
   logic [31:0]       w_wdata;
   logic              w_inrange;
   logic [AW-1:0]     w_idx;
   logic [31:0]       w_bank_rdata;

   assign w_accept = (r_state == ST_IDLE) && req;
   assign w_enter  = (w_next == ST_RESP) && (r_state != ST_RESP);

   // With zero wait states RESP is entered on the accept edge itself,
   // so the bank must see the live request rather than the holding regs.
   assign w_we    = (r_state == ST_IDLE) ? we    : r_we;
   assign w_addr  = (r_state == ST_IDLE) ? addr  : r_addr;
   assign w_be    = (r_state == ST_IDLE) ? be    : r_be;
   assign w_wdata = (r_state == ST_IDLE) ? wdata : r_wdata;

   // 33-bit compare so ADDR_BASE + DEPTH*4 cannot wrap.
   assign w_inrange = ({1'b0, w_addr} >= {1'b0, ADDR_BASE}) &&
                      ({1'b0, w_addr} < LIMIT);
   assign w_idx     = AW'((w_addr - ADDR_BASE) >> 2);

   dm_bank #(
      .DEPTH (DEPTH)
   ) u_bank (
      .clk     (clk),
      .i_en    (w_enter && w_inrange),
      .i_we    (w_we),
      .i_be    (w_be),
      .i_idx   (w_idx),
      .i_wdata (w_wdata),
      .o_rdata (w_bank_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         if (WAIT_CYCLES > 0) begin
            r_cnt <= WAIT_W'(WAIT_CYCLES - 1);
         end
      end else if (r_state == ST_WAIT && r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_be    <= '0;
         r_wdata <= '0;
      end else if (w_accept) begin
         r_we    <= we;
         r_addr  <= addr;
         r_be    <= be;
         r_wdata <= wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err <= 1'b0;
      end else if (w_enter) begin
         r_err <= !w_inrange;
      end
   end

   always_comb begin
      w_next     = r_state;
      busy       = (r_state != ST_IDLE);
      resp_valid = 1'b0;
      rdata      = '0;
      err        = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (req) begin
               w_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
            end
         end
         ST_WAIT: begin
            if (r_cnt == '0) begin
               w_next = ST_RESP;
            end
         end
         ST_RESP: begin
            w_next     = ST_IDLE;
            resp_valid = 1'b1;
            err        = r_err;
            if (!r_err && !r_we) begin
               rdata = w_bank_rdata;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder with WAIT_CYCLES of 1, 3 and 0.
// Instance index: 0 -> W=1, 1 -> W=3, 2 -> W=0.
module tb_dm_responder;

   logic        clk;
   logic        reset;
   logic [2:0]  req;
   logic [2:0]  we;
   logic [31:0] addr  [3];
   logic [3:0]  be    [3];
   logic [31:0] wdata [3];
   logic [2:0]  busy;
   logic [2:0]  resp_valid;
   logic [31:0] rdata [3];
   logic [2:0]  err;

   int checks;
   int errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   dm_responder #(.WAIT_CYCLES(1)) u_w1 (
      .clk(clk), .reset(reset), .req(req[0]), .we(we[0]),
      .addr(addr[0]), .be(be[0]), .wdata(wdata[0]),
      .busy(busy[0]), .resp_valid(resp_valid[0]),
      .rdata(rdata[0]), .err(err[0])
   );

   dm_responder #(.WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .reset(reset), .req(req[1]), .we(we[1]),
      .addr(addr[1]), .be(be[1]), .wdata(wdata[1]),
      .busy(busy[1]), .resp_valid(resp_valid[1]),
      .rdata(rdata[1]), .err(err[1])
   );

   dm_responder #(.WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .reset(reset), .req(req[2]), .we(we[2]),
      .addr(addr[2]), .be(be[2]), .wdata(wdata[2]),
      .busy(busy[2]), .resp_valid(resp_valid[2]),
      .rdata(rdata[2]), .err(err[2])
   );

   // One request; lat = negedges after accept until resp_valid (-1 = timeout).
   task automatic txn(
      input  int          d,
      input  logic        w,
      input  logic [31:0] a,
      input  logic [3:0]  b,
      input  logic [31:0] wd,
      output int          lat,
      output logic        b1,
      output logic [31:0] rd,
      output logic        e,
      output logic [1:0]  post
   );
      @(negedge clk);
      req[d]   = 1'b1;
      we[d]    = w;
      addr[d]  = a;
      be[d]    = b;
      wdata[d] = wd;
      @(posedge clk);
      #1 req[d] = 1'b0;
      lat  = -1;
      b1   = 1'b0;
      rd   = 32'hx;
      e    = 1'bx;
      post = 2'bxx;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 1) b1 = busy[d];
         if (resp_valid[d]) begin
            lat = i;
            rd  = rdata[d];
            e   = err[d];
            break;
         end
      end
      @(negedge clk);
      post = {busy[d], resp_valid[d]};
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({busy, resp_valid, err} !== 9'b0) begin
         errors++;
         $display("FAIL reset_flags got %b want 0",
                  {busy, resp_valid, err});
      end
      checks++;
      if ((rdata[0] | rdata[1] | rdata[2]) !== 32'h0) begin
         errors++;
         $display("FAIL reset_rdata got %h want 0",
                  rdata[0] | rdata[1] | rdata[2]);
      end
      reset = 1'b1;
   endtask

   task automatic test_write_read();
      int lat;
      logic b1, e;
      logic [31:0] rd;
      logic [1:0] post;
      txn(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, lat, b1, rd, e, post);
      checks++;
      if (lat !== 2) begin
         errors++;
         $display("FAIL wr_latency got %0d want 2", lat);
      end
      checks++;
      if (b1 !== 1'b1) begin
         errors++;
         $display("FAIL wr_busy got %b want 1", b1);
      end
      checks++;
      if (e !== 1'b0) begin
         errors++;
         $display("FAIL wr_err got %b want 0", e);
      end
      checks++;
      if (post !== 2'b00) begin
         errors++;
         $display("FAIL wr_post got %b want 00", post);
      end
      txn(0, 1'b0, 32'h10, 4'h0, 32'h0, lat, b1, rd, e, post);
      checks++;
      if (lat !== 2 || rd !== 32'hDEADBEEF || e !== 1'b0) begin
         errors++;
         $display("FAIL rd_10 got lat %0d %h %b want 2 deadbeef 0",
                  lat, rd, e);
      end
      txn(0, 1'b0, 32'h13, 4'h0, 32'h0, lat, b1, rd, e, post);
      checks++;
      if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
         errors++;
         $display("FAIL rd_13 got %h %b want deadbeef 0", rd, e);
      end
   endtask

   task automatic test_byte_lanes();
      int lat;
      logic b1, e;
      logic [31:0] rd;
      logic [1:0] post;
      txn(0, 1'b1, 32'h20, 4'hF, 32'h11223344, lat, b1, rd, e, post);
      txn(0, 1'b1, 32'h20, 4'b0010, 32'hAABBCCDD, lat, b1, rd, e, post);
      txn(0, 1'b0, 32'h20, 4'h0, 32'h0, lat, b1, rd, e, post);
      checks++;
      if (rd !== 32'h1122CC44) begin
         errors++;
         $display("FAIL lane_b1 got %h want 1122cc44", rd);
      end
      txn(0, 1'b1, 32'h20, 4'b1001, 32'h55667788, lat, b1, rd, e, post);
      txn(0, 1'b0, 32'h20, 4'hF, 32'h0, lat, b1, rd, e, post);
      checks++;
      if (rd !== 32'h5522CC88) begin
         errors++;
         $display("FAIL lane_b03 got %h want 5522cc88", rd);
      end
   endtask

   task automatic test_out_of_range();
      int lat;
      logic b1, e;
      logic [31:0] rd;
      logic [1:0] post;
      txn(0, 1'b1, 32'h0, 4'hF, 32'h01020304, lat, b1, rd, e, post);
      txn(0, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, lat, b1, rd, e, post);
      checks++;
      if (e !== 1'b1 || lat !== 2) begin
         errors++;
         $display("FAIL oor_wr got err %b lat %0d want 1 2", e, lat);
      end
      txn(0, 1'b0, 32'h1000, 4'hF, 32'h0, lat, b1, rd, e, post);
      checks++;
      if (e !== 1'b1 || rd !== 32'h0) begin
         errors++;
         $display("FAIL oor_rd got %b %h want 1 0", e, rd);
      end
      txn(0, 1'b0, 32'hFFFFFFFC, 4'hF, 32'h0, lat, b1, rd, e, post);
      checks++;
      if (e !== 1'b1) begin
         errors++;
         $display("FAIL oor_top got err %b want 1", e);
      end
      txn(0, 1'b0, 32'h0, 4'hF, 32'h0, lat, b1, rd, e, post);
      checks++;
      if (rd !== 32'h01020304 || e !== 1'b0) begin
         errors++;
         $display("FAIL word0 got %h %b want 01020304 0", rd, e);
      end
      txn(0, 1'b1, 32'hFFC, 4'hF, 32'hCAFEF00D, lat, b1, rd, e, post);
      txn(0, 1'b0, 32'hFFC, 4'hF, 32'h0, lat, b1, rd, e, post);
      checks++;
      if (rd !== 32'hCAFEF00D || e !== 1'b0) begin
         errors++;
         $display("FAIL last_word got %h %b want cafef00d 0", rd, e);
      end
   endtask

   task automatic test_back_to_back();
      logic [19:0] rv_obs, rv_exp, bz_obs, bz_exp;
      @(negedge clk);
      req[1]   = 1'b1;
      we[1]    = 1'b1;
      addr[1]  = 32'h40;
      be[1]    = 4'hF;
      wdata[1] = 32'h0BADF00D;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         rv_obs[i] = resp_valid[1];
         bz_obs[i] = busy[1];
         rv_exp[i] = ((i % 5) == 3);
         bz_exp[i] = ((i % 5) != 4);
      end
      req[1] = 1'b0;
      checks++;
      if (rv_obs !== rv_exp) begin
         errors++;
         $display("FAIL b2b_resp got %b want %b", rv_obs, rv_exp);
      end
      checks++;
      if (bz_obs !== bz_exp) begin
         errors++;
         $display("FAIL b2b_busy got %b want %b", bz_obs, bz_exp);
      end
   endtask

   task automatic test_reset_midop();
      int lat;
      logic b1, e;
      logic [31:0] rd;
      logic [1:0] post;
      txn(0, 1'b1, 32'h30, 4'hF, 32'h0, lat, b1, rd, e, post);
      @(negedge clk);
      req[0]   = 1'b1;
      we[0]    = 1'b1;
      addr[0]  = 32'h30;
      be[0]    = 4'hF;
      wdata[0] = 32'h55AA55AA;
      @(posedge clk);
      #1 req[0] = 1'b0;
      checks++;
      if (busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL mid_busy got %b want 1", busy[0]);
      end
      #1 reset = 1'b0;
      #1;
      checks++;
      if ({busy[0], resp_valid[0], err[0]} !== 3'b0 ||
          rdata[0] !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset got %b %h want 000 0",
                  {busy[0], resp_valid[0], err[0]}, rdata[0]);
      end
      @(negedge clk);
      reset = 1'b1;
      txn(0, 1'b0, 32'h30, 4'hF, 32'h0, lat, b1, rd, e, post);
      checks++;
      if (rd !== 32'h0 || e !== 1'b0) begin
         errors++;
         $display("FAIL mid_rd got %h %b want 0 0", rd, e);
      end
   endtask

   task automatic test_zero_wait();
      int lat;
      logic b1, e;
      logic [31:0] rd;
      logic [1:0] post;
      txn(2, 1'b1, 32'h8, 4'hF, 32'h13572468, lat, b1, rd, e, post);
      txn(2, 1'b0, 32'h8, 4'h0, 32'h0, lat, b1, rd, e, post);
      checks++;
      if (lat !== 1 || rd !== 32'h13572468) begin
         errors++;
         $display("FAIL w0_rd got lat %0d %h want 1 13572468", lat, rd);
      end
      checks++;
      if (post !== 2'b00) begin
         errors++;
         $display("FAIL w0_post got %b want 00", post);
      end
      txn(2, 1'b1, 32'h8, 4'h0, 32'hFFFFFFFF, lat, b1, rd, e, post);
      checks++;
      if (lat !== 1 || e !== 1'b0) begin
         errors++;
         $display("FAIL w0_be0 got lat %0d err %b want 1 0", lat, e);
      end
      txn(2, 1'b0, 32'h8, 4'h0, 32'h0, lat, b1, rd, e, post);
      checks++;
      if (rd !== 32'h13572468) begin
         errors++;
         $display("FAIL w0_keep got %h want 13572468", rd);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      req    = '0;
      we     = '0;
      for (int i = 0; i < 3; i++) begin
         addr[i]  = '0;
         be[i]    = '0;
         wdata[i] = '0;
      end
      repeat (3) @(posedge clk);
      test_reset();
      test_write_read();
      test_byte_lanes();
      test_out_of_range();
      test_back_to_back();
      repeat (4) @(negedge clk);
      test_reset_midop();
      test_zero_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
